mr_alu_issue: RTL and testbench

Issue/decode stage that drives the single-cycle-registered ALU (`mr_alu`) and collects its result. It accepts one RV32I OP/OP-IMM instruction with its operand values over a valid/ready handshake, decodes it to an `e_aluops` opcode and two arguments, and holds them stable while the ALU computes. It then presents the ALU result with the destination register on a valid/ready writeback port. It sits between register read and writeback in the mr core's integer path.

---
 rtl/mr_alu_issue.sv | 204 ++++++++++++++++++++
 tb/tb_mr_alu_issue.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mr_alu_issue.sv
// mr_alu_issue -- issue/decode stage in front of the registered ALU (mr_alu).
//
// Accepts one RV32I OP / OP-IMM instruction plus its operand values, decodes
// it into an ALU opcode and two arguments, holds those stable while mr_alu
// computes, then offers the result on a writeback port.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   in_valid / in_ready      instruction handshake
//   in_insn                  raw 32-bit instruction word
//   in_rs1_val, in_rs2_val   register operands (rs2 unused for OP-IMM)
//   alu_op, alu_arg1/2       registered ALU inputs (to mr_alu)
//   alu_dest                 registered ALU result (from mr_alu)
//   wb_valid / wb_ready      writeback handshake
//   wb_rd, wb_data           destination index and result
//   wb_illegal               instruction was not a legal OP/OP-IMM

package mr_alu_pkg;
  localparam int XLEN = 32;

  typedef enum logic [3:0] {
    ALU_ADD     = 4'd0,
    ALU_SUB     = 4'd1,
    ALU_SH_L    = 4'd2,
    ALU_SH_RL   = 4'd3,
    ALU_SH_RA   = 4'd4,
    ALU_CMP_LT  = 4'd5,
    ALU_CMP_LTU = 4'd6,
    ALU_XOR     = 4'd7,
    ALU_OR      = 4'd8,
    ALU_AND     = 4'd9
  } e_aluops;
endpackage

module mr_alu_issue
  import mr_alu_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_insn,
  input  logic [XLEN-1:0] in_rs1_val,
  input  logic [XLEN-1:0] in_rs2_val,
  output e_aluops         alu_op,
  output logic [XLEN-1:0] alu_arg1,
  output logic [XLEN-1:0] alu_arg2,
  input  logic [XLEN-1:0] alu_dest,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            wb_illegal
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] F7_ZERO    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } e_state;

  e_state state_reg, state_next;

  e_aluops         alu_op_reg;
  logic [XLEN-1:0] alu_arg1_reg, alu_arg2_reg;
  logic [4:0]      wb_rd_reg;
  logic            wb_illegal_reg;

  // ---------------------------------------------------------------- decode
  logic [6:0]      opcode, funct7;
  logic [2:0]      funct3;
  logic            is_op, is_op_imm;
  logic [XLEN-1:0] imm_sext, src2;

  // rs1/rs2 indices are resolved by register read upstream; only the
  // operand values matter here.
  logic unused_rs1_idx;
  assign unused_rs1_idx = ^in_insn[19:15];

  assign opcode    = in_insn[6:0];
  assign funct3    = in_insn[14:12];
  assign funct7    = in_insn[31:25];
  assign is_op     = (opcode == OPC_OP);
  assign is_op_imm = (opcode == OPC_OP_IMM);
  assign imm_sext  = {{(XLEN-12){in_insn[31]}}, in_insn[31:20]};
  assign src2      = is_op ? in_rs2_val : imm_sext;

  e_aluops         dec_op;
  logic            dec_legal, dec_shift;
  logic [XLEN-1:0] dec_arg1, dec_arg2;

  always_comb begin
    dec_op    = ALU_ADD;
    dec_legal = 1'b0;
    dec_shift = 1'b0;
    dec_arg1  = '0;
    dec_arg2  = '0;

    if (is_op || is_op_imm) begin
      unique case (funct3)
        3'b000: begin
          if (is_op_imm || funct7 == F7_ZERO) begin
            dec_op    = ALU_ADD;
            dec_legal = 1'b1;
          end else if (funct7 == F7_ALT) begin
            dec_op    = ALU_SUB;
            dec_legal = 1'b1;
          end
        end
        3'b001: begin
          // SLLI uses insn[31:25] as a funct7 field too, so one check covers both.
          dec_op    = ALU_SH_L;
          dec_shift = 1'b1;
          dec_legal = (funct7 == F7_ZERO);
        end
        3'b101: begin
          dec_shift = 1'b1;
          if (funct7 == F7_ZERO) begin
            dec_op    = ALU_SH_RL;
            dec_legal = 1'b1;
          end else if (funct7 == F7_ALT) begin
            dec_op    = ALU_SH_RA;
            dec_legal = 1'b1;
          end
        end
        default: begin
          unique case (funct3)
            3'b010:  dec_op = ALU_CMP_LT;
            3'b011:  dec_op = ALU_CMP_LTU;
            3'b100:  dec_op = ALU_XOR;
            3'b110:  dec_op = ALU_OR;
            default: dec_op = ALU_AND;
          endcase
          // For OP-IMM these upper bits are immediate, not funct7.
          dec_legal = is_op_imm || (funct7 == F7_ZERO);
        end
      endcase
    end

    if (dec_legal) begin
      dec_arg1 = in_rs1_val;
      dec_arg2 = dec_shift ? {{(XLEN-5){1'b0}}, src2[4:0]} : src2;
    end else begin
      // Illegal instructions run as ADD 0,0 so the pipeline timing is uniform.
      dec_op = ALU_ADD;
    end
  end

  // ------------------------------------------------------------------- FSM
  logic in_fire;

  assign in_ready = !rst && (state_reg == ST_IDLE || (state_reg == ST_WB && wb_ready));
  assign in_fire  = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      ST_IDLE: if (in_fire) state_next = ST_EXEC;
      ST_EXEC: state_next = ST_WB;
      ST_WB: begin
        if (wb_ready) state_next = in_fire ? ST_EXEC : ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // ------------------------------------------------- latched ALU inputs / wb
  // Held from the transfer edge until the next transfer so that alu_dest
  // stays stable for the whole writeback phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_op_reg     <= ALU_ADD;
      alu_arg1_reg   <= '0;
      alu_arg2_reg   <= '0;
      wb_rd_reg      <= '0;
      wb_illegal_reg <= 1'b0;
    end else if (in_fire) begin
      alu_op_reg     <= dec_op;
      alu_arg1_reg   <= dec_arg1;
      alu_arg2_reg   <= dec_arg2;
      wb_rd_reg      <= in_insn[11:7];
      wb_illegal_reg <= !dec_legal;
    end
  end

  assign alu_op     = alu_op_reg;
  assign alu_arg1   = alu_arg1_reg;
  assign alu_arg2   = alu_arg2_reg;
  assign wb_valid   = (state_reg == ST_WB);
  assign wb_rd      = wb_rd_reg;
  assign wb_illegal = wb_illegal_reg;
  assign wb_data    = (wb_illegal_reg || wb_rd_reg == 5'd0) ? '0 : alu_dest;

endmodule

// File: tb/tb_mr_alu_issue.sv
module tb_mr_alu_issue;
  import mr_alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_insn, in_rs1_val, in_rs2_val;
  e_aluops     alu_op;
  logic [31:0] alu_arg1, alu_arg2, alu_dest;
  logic        wb_valid, wb_ready, wb_illegal;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mr_alu_issue dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_insn(in_insn),
    .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val),
    .alu_op(alu_op), .alu_arg1(alu_arg1), .alu_arg2(alu_arg2), .alu_dest(alu_dest),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd),
    .wb_data(wb_data), .wb_illegal(wb_illegal)
  );

  // Stand-in for mr_alu: registers its result one edge after the inputs.
  always @(posedge clk) begin
    case (alu_op)
      ALU_ADD:     alu_dest <= alu_arg1 + alu_arg2;
      ALU_SUB:     alu_dest <= alu_arg1 - alu_arg2;
      ALU_SH_L:    alu_dest <= alu_arg1 << alu_arg2[4:0];
      ALU_SH_RL:   alu_dest <= alu_arg1 >> alu_arg2[4:0];
      ALU_SH_RA:   alu_dest <= $unsigned($signed(alu_arg1) >>> alu_arg2[4:0]);
      ALU_CMP_LT:  alu_dest <= {31'b0, $signed(alu_arg1) < $signed(alu_arg2)};
      ALU_CMP_LTU: alu_dest <= {31'b0, alu_arg1 < alu_arg2};
      ALU_XOR:     alu_dest <= alu_arg1 ^ alu_arg2;
      ALU_OR:      alu_dest <= alu_arg1 | alu_arg2;
      ALU_AND:     alu_dest <= alu_arg1 & alu_arg2;
      default:     alu_dest <= 32'hDEAD_BEEF;
    endcase
  end

  localparam logic [6:0] OP  = 7'b0110011;
  localparam logic [6:0] IMM = 7'b0010011;

  function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, OP};
  endfunction

  function automatic logic [31:0] i_type(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, IMM};
  endfunction

  // Architectural result of one instruction, straight from the ISA rules.
  function automatic void ref_model(input logic [31:0] insn, input logic [31:0] a,
                                    input logic [31:0] rs2v, output logic ill,
                                    output logic [31:0] res);
    logic [6:0]  opc, f7;
    logic [2:0]  f3;
    logic [31:0] b;
    logic [4:0]  sh;
    opc = insn[6:0]; f3 = insn[14:12]; f7 = insn[31:25];
    b   = (opc == OP) ? rs2v : {{20{insn[31]}}, insn[31:20]};
    sh  = b[4:0];
    ill = 1'b0;
    res = 32'd0;
    if (opc != OP && opc != IMM) ill = 1'b1;
    else begin
      case (f3)
        3'd0: if (opc == OP && f7 == 7'h20) res = a - b;
              else if (opc == OP && f7 != 7'h00) ill = 1'b1;
              else res = a + b;
        3'd1: if (f7 != 7'h00) ill = 1'b1; else res = a << sh;
        3'd5: if (f7 == 7'h00) res = a >> sh;
              else if (f7 == 7'h20) res = $unsigned($signed(a) >>> sh);
              else ill = 1'b1;
        default: if (opc == OP && f7 != 7'h00) ill = 1'b1;
          else case (f3)
            3'd2: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: res = (a < b) ? 32'd1 : 32'd0;
            3'd4: res = a ^ b;
            3'd6: res = a | b;
            default: res = a & b;
          endcase
      endcase
    end
    if (ill || insn[11:7] == 5'd0) res = 32'd0;
  endfunction

  // Present an instruction and hold it until accepted (bounded).
  task automatic offer(input logic [31:0] insn, input logic [31:0] a, input logic [31:0] b,
                       output bit ok);
    ok = 1'b0;
    @(negedge clk);
    in_insn = insn; in_rs1_val = a; in_rs2_val = b; in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (in_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL accept: in_ready=0 required 1 within 20 cycles");
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    in_insn = $urandom; in_rs1_val = $urandom; in_rs2_val = $urandom;
  endtask

  // Issue one instruction with wb_ready=1 and check the writeback.
  task automatic run_one(input string name, input logic [31:0] insn, input logic [31:0] a,
                         input logic [31:0] b, input logic exp_ill, input logic [31:0] exp_data);
    bit ok;
    int cyc;
    wb_ready = 1'b1;
    offer(insn, a, b, ok);
    if (!ok) return;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!wb_valid && cyc < 10);
    checks++;
    if (cyc !== 2) begin
      errors++; $display("FAIL %s latency: got %0d cycles required 2", name, cyc);
    end
    checks++;
    if (wb_rd !== insn[11:7] || wb_data !== exp_data || wb_illegal !== exp_ill) begin
      errors++;
      $display("FAIL %s wb: rd=%0d data=%08h ill=%0b required rd=%0d data=%08h ill=%0b",
               name, wb_rd, wb_data, wb_illegal, insn[11:7], exp_data, exp_ill);
    end
    @(negedge clk);
    checks++;
    if (wb_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL %s idle: wb_valid=%0b in_ready=%0b required 0/1", name, wb_valid, in_ready);
    end
    $display("txn %-10s insn=%08h rs1=%08h rs2=%08h -> rd=%0d data=%08h ill=%0b",
             name, insn, a, b, wb_rd, exp_data, exp_ill);
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; wb_ready = 1'b0;
    in_insn = '0; in_rs1_val = '0; in_rs2_val = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || wb_valid !== 1'b0 || alu_op !== ALU_ADD || alu_arg1 !== 32'd0 ||
        alu_arg2 !== 32'd0 || wb_rd !== 5'd0 || wb_illegal !== 1'b0) begin
      errors++;
      $display("FAIL reset: rdy=%0b v=%0b op=%0d a1=%08h a2=%08h rd=%0d ill=%0b required all 0",
               in_ready, wb_valid, alu_op, alu_arg1, alu_arg2, wb_rd, wb_illegal);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release: in_ready=%0b required 1", in_ready);
    end
    $display("txn reset done");
  endtask

  task automatic test_decode();
    run_one("add",   r_type(7'h00, 5'd2, 5'd1, 3'd0, 5'd3), 32'd5, 32'd7, 1'b0, 32'd12);
    run_one("sub",   r_type(7'h20, 5'd2, 5'd1, 3'd0, 5'd4), 32'd3, 32'd5, 1'b0, 32'hFFFF_FFFE);
    run_one("slti",  i_type(12'd1, 5'd1, 3'd2, 5'd5), 32'hFFFF_FFFF, 32'h0, 1'b0, 32'd1);
    run_one("sltiu", i_type(12'd1, 5'd1, 3'd3, 5'd6), 32'hFFFF_FFFF, 32'h0, 1'b0, 32'd0);
    run_one("sll",   r_type(7'h00, 5'd2, 5'd1, 3'd1, 5'd7), 32'd1, 32'h21, 1'b0, 32'd2);
    run_one("andi",  i_type(12'hF0F, 5'd1, 3'd7, 5'd8), 32'hFFFF_FFFF, 32'h0, 1'b0, 32'hFFFF_FF0F);
    run_one("srai",  i_type(12'h41F, 5'd1, 3'd5, 5'd9), 32'h8000_0000, 32'h0, 1'b0, 32'hFFFF_FFFF);
  endtask

  task automatic test_illegal_rd0();
    run_one("ill_opc", {12'd5, 5'd1, 3'd0, 5'd10, 7'b0000011}, 32'd9, 32'd9, 1'b1, 32'd0);
    run_one("ill_f7",  r_type(7'h01, 5'd2, 5'd1, 3'd0, 5'd11), 32'd9, 32'd9, 1'b1, 32'd0);
    run_one("ill_slli", i_type(12'h403, 5'd1, 3'd1, 5'd12), 32'd9, 32'd9, 1'b1, 32'd0);
    run_one("addi_x0", i_type(12'd77, 5'd1, 3'd0, 5'd0), 32'd100, 32'd0, 1'b0, 32'd0);
  endtask

  task automatic test_random();
    logic [31:0] insn, a, b, exp;
    logic ill;
    logic [6:0] f7;
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 3))
        0: f7 = 7'h20;
        1: f7 = 7'($urandom);
        default: f7 = 7'h00;
      endcase
      insn = {f7, 5'($urandom), 5'($urandom), 3'($urandom), 5'($urandom),
              ($urandom_range(0, 9) == 0) ? 7'($urandom) : (($urandom_range(0, 1) == 1) ? OP : IMM)};
      a = $urandom; b = $urandom;
      if ($urandom_range(0, 3) == 0) b = $urandom_range(0, 40);
      ref_model(insn, a, b, ill, exp);
      run_one("random", insn, a, b, ill, exp);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] insn_a, insn_b, exp_a, exp_b;
    logic ill_a, ill_b;
    bit ok, bad;
    int cyc;
    insn_a = r_type(7'h00, 5'd2, 5'd1, 3'd6, 5'd13);
    insn_b = i_type(12'hFFF, 5'd1, 3'd0, 5'd14);
    ref_model(insn_a, 32'h1200_0034, 32'h0000_5600, ill_a, exp_a);
    ref_model(insn_b, 32'd50, 32'd0, ill_b, exp_b);
    wb_ready = 1'b0;
    offer(insn_a, 32'h1200_0034, 32'h0000_5600, ok);
    if (!ok) return;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!wb_valid && cyc < 10);
    checks++;
    if (!wb_valid || wb_data !== exp_a || wb_rd !== 5'd13) begin
      errors++; $display("FAIL stall_first: v=%0b data=%08h required 1/%08h", wb_valid, wb_data, exp_a);
    end
    // New instruction waits while writeback is stalled.
    in_insn = insn_b; in_rs1_val = 32'd50; in_rs2_val = 32'd0; in_valid = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (!wb_valid || in_ready || wb_data !== exp_a || wb_rd !== 5'd13 || wb_illegal !== 1'b0)
        bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++; $display("FAIL stall_hold: v=%0b rdy=%0b data=%08h required 1/0/%08h",
                         wb_valid, in_ready, wb_data, exp_a);
    end
    wb_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL overlap_ready: in_ready=%0b required 1", in_ready);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (wb_valid !== 1'b0) begin
      errors++; $display("FAIL overlap_exec: wb_valid=%0b required 0", wb_valid);
    end
    @(negedge clk);
    checks++;
    if (wb_valid !== 1'b1 || wb_data !== exp_b || wb_rd !== 5'd14 || wb_illegal !== ill_b) begin
      errors++; $display("FAIL overlap_second: v=%0b data=%08h rd=%0d required 1/%08h/14",
                         wb_valid, wb_data, wb_rd, exp_b);
    end
    @(negedge clk);
    $display("txn back_to_back first=%08h second=%08h", exp_a, exp_b);
  endtask

  task automatic test_reset_midop();
    bit ok, seen;
    wb_ready = 1'b1;
    offer(r_type(7'h00, 5'd2, 5'd1, 3'd0, 5'd15), 32'd1, 32'd2, ok);
    if (!ok) return;
    @(negedge clk);  // state is EXEC here
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (alu_op !== ALU_ADD || alu_arg1 !== 32'd0 || alu_arg2 !== 32'd0 || wb_valid !== 1'b0 ||
        in_ready !== 1'b0) begin
      errors++; $display("FAIL rst_midop: op=%0d a1=%08h a2=%08h v=%0b rdy=%0b required 0",
                         alu_op, alu_arg1, alu_arg2, wb_valid, in_ready);
    end
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 1) rst = 1'b0;
      if (wb_valid) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++; $display("FAIL rst_no_wb: wb_valid seen=1 required 0");
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL rst_ready: in_ready=%0b required 1", in_ready);
    end
    $display("txn reset_midop");
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_decode();
    test_illegal_rd0();
    test_random();
    test_back_to_back();
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
